// File: rtl/led_ctrl.sv
// Wishbone-slave LED controller: pattern register, tick prescaler and static/blink/rotate modes.
// Build option LED_CTRL_PWM_EN adds a DUTY register at 0x10 and a PWM brightness mask on led_o.
module led_ctrl #(
  parameter logic [31:0] PERIOD_RST  = 32'd1000,
  parameter logic [7:0]  PATTERN_RST = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
`ifdef LED_CTRL_PWM_EN
  input  logic [4:0]  wb_adr_i,
`else
  input  logic [3:0]  wb_adr_i,
`endif
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  led_o
);

  localparam logic [1:0] ST_STATIC = 2'd0;
  localparam logic [1:0] ST_BLINK  = 2'd1;
  localparam logic [1:0] ST_ROTATE = 2'd2;

  logic [7:0]  pattern_q, pattern_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  rot_q, rot_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  led_q, led_d;

  logic [2:0]  reg_idx_s;
  logic        req_s, wr_s, pat_wr_s, ctrl_wr_s, per_wr_s, reload_s, tick_s;
  logic [31:0] load_val_s, rdata_s, status_s;
  logic [7:0]  mode_out_s, pwm_mask_s;
  logic        unused_adr_s;

`ifdef LED_CTRL_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_q, pwm_d;
  logic       duty_wr_s;
  assign reg_idx_s = wb_adr_i[4:2];
`else
  assign reg_idx_s = {1'b0, wb_adr_i[3:2]};
`endif
  assign unused_adr_s = ^wb_adr_i[1:0];

  // Bus decode, prescaler, mode state machine and read mux.
  always_comb begin
    req_s     = wb_cyc_i & wb_stb_i & ~ack_q;
    wr_s      = req_s & wb_we_i;
    pat_wr_s  = wr_s & (reg_idx_s == 3'd0) & wb_sel_i[0];
    ctrl_wr_s = wr_s & (reg_idx_s == 3'd1) & wb_sel_i[0];
    per_wr_s  = wr_s & (reg_idx_s == 3'd2);
    reload_s  = ctrl_wr_s | per_wr_s;
    // A reload cycle never ticks, so a config write always restarts a full period.
    tick_s    = (cnt_q == 32'd0) & ~reload_s;

    pattern_d = pat_wr_s  ? wb_dat_i[7:0] : pattern_q;
    ctrl_d    = ctrl_wr_s ? wb_dat_i[1:0] : ctrl_q;
    period_d  = period_q;
    for (int b = 0; b < 4; b++) begin
      if (per_wr_s && wb_sel_i[b]) begin
        period_d[8*b +: 8] = wb_dat_i[8*b +: 8];
      end else begin
        period_d[8*b +: 8] = period_q[8*b +: 8];
      end
    end

    load_val_s = (period_d == 32'd0) ? 32'd0 : (period_d - 32'd1);
    if (reload_s || tick_s) begin
      cnt_d = load_val_s;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end

    if (ctrl_wr_s) begin
      tick_cnt_d = 16'd0;
    end else if (tick_s) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    state_d = state_q;
    phase_d = phase_q;
    rot_d   = rot_q;
    if (ctrl_wr_s) begin
      state_d = (ctrl_d == 2'd3) ? ST_STATIC : ctrl_d;
      phase_d = 1'b0;
      rot_d   = pattern_q;
    end else begin
      case (state_q)
        ST_BLINK: begin
          if (tick_s) phase_d = ~phase_q;
          else        phase_d = phase_q;
        end
        ST_ROTATE: begin
          // A pattern write beats a simultaneous tick.
          if (pat_wr_s)    rot_d = pattern_d;
          else if (tick_s) rot_d = {rot_q[6:0], rot_q[7]};
          else             rot_d = rot_q;
        end
        default: ;
      endcase
    end

    case (state_d)
      ST_BLINK:  mode_out_s = phase_d ? 8'h00 : pattern_d;
      ST_ROTATE: mode_out_s = rot_d;
      default:   mode_out_s = pattern_d;
    endcase

`ifdef LED_CTRL_PWM_EN
    duty_wr_s  = wr_s & (reg_idx_s == 3'd4) & wb_sel_i[0];
    duty_d     = duty_wr_s ? wb_dat_i[7:0] : duty_q;
    pwm_d      = pwm_q + 8'd1;
    pwm_mask_s = {8{pwm_q < duty_q}};
    status_s   = {7'd0, duty_q, phase_q, tick_cnt_q};
`else
    pwm_mask_s = 8'hFF;
    status_s   = {15'd0, phase_q, tick_cnt_q};
`endif
    led_d = mode_out_s & pwm_mask_s;

    case (reg_idx_s)
      3'd0:    rdata_s = {24'd0, pattern_q};
      3'd1:    rdata_s = {30'd0, ctrl_q};
      3'd2:    rdata_s = period_q;
      3'd3:    rdata_s = status_s;
`ifdef LED_CTRL_PWM_EN
      3'd4:    rdata_s = {24'd0, duty_q};
`endif
      default: rdata_s = 32'd0;
    endcase

    ack_d = req_s;
    dat_d = (req_s && !wb_we_i) ? rdata_s : 32'd0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q  <= PATTERN_RST;
      ctrl_q     <= 2'd0;
      state_q    <= ST_STATIC;
      period_q   <= PERIOD_RST;
      cnt_q      <= PERIOD_RST - 32'd1;
      tick_cnt_q <= 16'd0;
      phase_q    <= 1'b0;
      rot_q      <= PATTERN_RST;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      led_q      <= 8'h00;
`ifdef LED_CTRL_PWM_EN
      duty_q     <= 8'hFF;
      pwm_q      <= 8'd0;
`endif
    end else begin
      pattern_q  <= pattern_d;
      ctrl_q     <= ctrl_d;
      state_q    <= state_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      rot_q      <= rot_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      led_q      <= led_d;
`ifdef LED_CTRL_PWM_EN
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign led_o    = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed self-checking bench for led_ctrl; read data goes through an expected-value queue.
module tb_led_ctrl;

`ifdef LED_CTRL_PWM_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] dat_o;
  logic        ack;
  logic [7:0]  led;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  led_ctrl dut (
    .clk(clk), .rst(rst), .wb_adr_i(adr[AW-1:0]), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .led_o(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the ack cycle.
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick1();
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) check("write_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bit got = 1'b0;
    logic [31:0] e;
    exp_q.push_back(exp);
    adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick1();
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    e = exp_q.pop_front();
    if (got) check(tag, dat_o, e);
    else     check({tag, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_led;
    int on_cnt;
    rst = 1'b1; adr = 5'd0; dat_i = 32'd0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) tick1();
    check("rst_led", {24'd0, led}, 32'h0000_0000);
    check("rst_ack", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    tick1();
    check("post_rst_led", {24'd0, led}, 32'h0000_0001);
    check("post_rst_ack", {31'd0, ack}, 32'd0);
    wb_read("status_rst", 5'h0C, 32'h0000_0000);

    // Pattern write / readback and single-cycle ack
    wb_write(5'h00, 32'h0000_00A5, 4'h1);
    check("pat_led", {24'd0, led}, 32'h0000_00A5);
    tick1();
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    check("dat_zero_idle", dat_o, 32'd0);
    wb_read("pat_read", 5'h00, 32'h0000_00A5);

    // Blink, PERIOD=4
    wb_write(5'h08, 32'd4, 4'hF);
    wb_write(5'h00, 32'h0000_00FF, 4'h1);
    wb_write(5'h04, 32'd1, 4'h1);
    check("blink_start", {24'd0, led}, 32'h0000_00FF);
    for (int i = 1; i <= 12; i++) begin
      tick1();
      exp_led = (((i / 4) % 2) == 1) ? 8'h00 : 8'hFF;
      check($sformatf("blink_%0d", i), {24'd0, led}, {24'd0, exp_led});
    end
    wb_read("blink_status", 5'h0C, 32'h0001_0003);

    // Rotate, PERIOD=0
    wb_write(5'h08, 32'd0, 4'hF);
    wb_write(5'h00, 32'h0000_0081, 4'h1);
    wb_write(5'h04, 32'd2, 4'h1);
    exp_led = 8'h81;
    check("rot_start", {24'd0, led}, {24'd0, exp_led});
    for (int i = 1; i <= 8; i++) begin
      tick1();
      exp_led = {exp_led[6:0], exp_led[7]};
      check($sformatf("rot_%0d", i), {24'd0, led}, {24'd0, exp_led});
    end
    check("rot_wrap", {24'd0, led}, 32'h0000_0081);

    // Rotate PERIOD=2, pattern write lands on a tick cycle
    wb_write(5'h08, 32'd2, 4'hF);
    wb_write(5'h00, 32'h0000_0010, 4'h1);
    check("rot_wr_tick", {24'd0, led}, 32'h0000_0010);
    tick1();
    check("rot_hold", {24'd0, led}, 32'h0000_0010);
    tick1();
    check("rot_after", {24'd0, led}, 32'h0000_0020);

    // Reset mid-blink with a read pending
    wb_write(5'h04, 32'd1, 4'h1);
    adr = 5'h00; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    tick1();
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_led", {24'd0, led}, 32'h0000_0000);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick1();
    check("mid_rst_ack2", {31'd0, ack}, 32'd0);
    check("mid_rst_led2", {24'd0, led}, 32'h0000_0001);
    wb_read("rst_pattern", 5'h00, 32'h0000_0001);
    wb_read("rst_ctrl", 5'h04, 32'h0000_0000);
    wb_read("rst_period", 5'h08, 32'h0000_03E8);
    wb_read("rst_status", 5'h0C, 32'h0000_0000);

    // STATUS is read-only; reserved mode 3 behaves as static
    wb_write(5'h0C, 32'hFFFF_FFFF, 4'hF);
    wb_read("status_ro", 5'h0C, 32'h0000_0000);
    wb_write(5'h04, 32'd3, 4'h1);
    wb_read("ctrl_mode3", 5'h04, 32'h0000_0003);
    check("mode3_led", {24'd0, led}, 32'h0000_0001);

`ifdef LED_CTRL_PWM_EN
    wb_write(5'h10, 32'h0000_0040, 4'h1);
    wb_read("duty_read", 5'h10, 32'h0000_0040);
    tick1();
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick1();
      if (led != 8'h00) on_cnt++;
    end
    check("pwm_on_count", on_cnt, 32'd64);
`else
    on_cnt = 0;
    wb_read("alias_0x10", 5'h10, 32'h0000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
Wishbone-slave controller for the 8-bit SoC LED port. It holds the LED pattern register and schedules pattern updates from a programmable tick prescaler. Supported modes are static, blink and rotate. It sits on the system bus next to the CPU and drives the top-level led pins, so software can produce timed pulses without polling.

Parameters:
PERIOD_RST, 32'd1000, reset value of the PERIOD register (clk cycles per tick)
PATTERN_RST, 8'h01, reset value of the PATTERN register

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
wb_adr_i  input  4  byte address; [3:2] selects the register, [1:0] ignored
wb_dat_i  input  32  write data
wb_sel_i  input  4  byte enables; only [0] used, except PERIOD uses all four
wb_we_i  input  1  write enable
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_dat_o  output  32  read data
wb_ack_o  output  1  acknowledge
led_o  output  8  LED drive, active-high

Behaviour:
- Register map:
  - 0x0 PATTERN[7:0] (rw)
  - 0x4 CTRL[1:0] (rw): mode, 0=STATIC, 1=BLINK, 2=ROTATE, 3=reserved and treated as STATIC
  - 0x8 PERIOD[31:0] (rw)
  - 0xC STATUS (ro): [15:0] tick_cnt, [16] phase
- Unused read bits return 0. Writes to STATUS are acked and ignored.
- Bus handshake:
  - wb_ack_o rises one cycle after cyc&stb&!ack and stays high exactly 1 cycle.
  - Back-to-back strobes are therefore acked every other cycle.
  - Write side effects and registered read data both occur on the ack cycle.
  - wb_dat_o is 0 when wb_ack_o=0.
- Prescaler:
  - 32-bit down-counter loaded with max(PERIOD,1)-1.
  - tick pulses 1 cycle when the counter is 0 and the counter reloads on that cycle.
  - PERIOD=0 or 1 gives a tick every cycle.
  - A write to PERIOD or CTRL reloads the counter on the ack cycle, and no tick is issued that cycle.
- State machine (state = effective mode), transitions only on a CTRL write:
  - STATIC: led_o = PATTERN. Ticks still count.
  - BLINK: phase toggles on each tick. led_o = phase ? 8'h00 : PATTERN.
  - ROTATE: a working register rot, loaded from PATTERN on entry, rotates left by 1 on each tick (bit7->bit0). led_o = rot.
  - On entry to any state: phase=0, rot=PATTERN.
  - A PATTERN write while in ROTATE reloads rot immediately (same ack cycle) and does not clear phase.
- tick_cnt:
  - Increments on each tick and wraps 16'hFFFF->0.
  - Cleared on a CTRL write.
- led_o is registered: it changes the cycle after the tick or write that causes it.
- Simultaneous tick and PATTERN write in ROTATE: the write wins (rot=new PATTERN, no rotate that cycle). tick_cnt still increments.
- Reset (any cycle, including mid-transfer):
  - PATTERN=PATTERN_RST, CTRL=0, PERIOD=PERIOD_RST, counter=PERIOD_RST-1.
  - tick_cnt=0, phase=0, rot=PATTERN_RST.
  - wb_ack_o=0, wb_dat_o=0, led_o=8'h00.
  - A transfer in progress is dropped and no ack is generated for it.
  - led_o shows PATTERN from the first cycle after reset.

Optional Feature:
LED_CTRL_PWM_EN
- Defined:
  - Adds register 0x10 (wb_adr_i widened to 5 bits) DUTY[7:0] (rw), reset value 8'hFF.
  - A free-running 8-bit counter pwm increments every clk.
  - Final led_o = mode output AND {8{pwm < DUTY}}. DUTY=0 means always off; DUTY=FF means on for 255 of 256 cycles.
  - STATUS bit [24:17] mirrors DUTY.
- Undefined:
  - No DUTY register, no pwm logic, wb_adr_i stays 4 bits.
  - 0x10 aliases 0x0.
  - led_o equals the mode output directly.

Test Plan:
- Reset release, no writes -> led_o=8'h01 from the cycle after reset, wb_ack_o=0, STATUS reads 0x0.
- Write PATTERN=0xA5, read back -> ack 1 cycle after strobe, read data 0x000000A5, led_o=0xA5 next cycle.
- PERIOD=4, CTRL=1, PATTERN=0xFF -> led_o toggles between 0x00 and 0xFF every 4 clk; STATUS tick_cnt=3 after 12 cycles.
- PERIOD=0, CTRL=2, PATTERN=0x81 -> led_o sequence 0x81, 0x03, 0x06, 0x0C, one step per clk; wraps to 0x81 after 8 ticks.
- ROTATE with PERIOD=2, write PATTERN=0x10 on a tick cycle -> led_o=0x10 (no rotate that cycle), then 0x20 two cycles later.
- Assert rst mid-BLINK with ack pending -> no ack, all registers at reset values, led_o=0x01 the cycle after rst drops; with LED_CTRL_PWM_EN, DUTY=0x40 gives LED on for 64 of every 256 cycles.
